// File: rtl/mem_responder_if.sv
// Request/response bundle between the cache side (master) and mem_responder
// (slave). The err signal exists only when MEM_RESP_RANGE_CHECK_EN is defined.
interface mem_responder_if #(
    parameter int d_width = 8,
    parameter int a_width = 8
);
    logic               req;
    logic               rw;
    logic [a_width-1:0] addr;
    logic [d_width-1:0] wdata;
    logic               ready;
    logic               busy;
    logic               ack;
    logic [d_width-1:0] rdata;
`ifdef MEM_RESP_RANGE_CHECK_EN
    logic               err;
`endif

    modport master (
        output req, rw, addr, wdata,
`ifdef MEM_RESP_RANGE_CHECK_EN
        input  err,
`endif
        input  ready, busy, ack, rdata
    );

    modport slave (
        input  req, rw, addr, wdata,
`ifdef MEM_RESP_RANGE_CHECK_EN
        output err,
`endif
        output ready, busy, ack, rdata
    );
endinterface

// File: rtl/mem_responder.sv
// mem_responder: 8-word memory behind a fixed-latency request handshake.
// A request accepted in IDLE waits LATENCY cycles, performs the access,
// then pulses ack for one cycle. Requests arriving while busy are dropped.
// Optional feature macro: MEM_RESP_RANGE_CHECK_EN -- addresses above 7 are
// rejected (no write, rdata=0, err pulsed with ack) instead of aliasing.
//
// state     | meaning
// ----------+-----------------------------------------------
// ST_IDLE   | ready, waiting for req
// ST_WAIT   | latency countdown, cnt counts LATENCY-1 .. 0
// ST_ACCESS | storage read/write happens at the exiting edge
// ST_DONE   | ack high for one cycle, then back to IDLE
module mem_responder #(
    parameter int d_width = 8,
    parameter int a_width = 8,
    parameter int LATENCY = 3
) (
    input  logic               clk,
    input  logic               clr,
    mem_responder_if.slave     bus,
    output logic [d_width-1:0] mem0,
    output logic [d_width-1:0] mem1,
    output logic [d_width-1:0] mem2,
    output logic [d_width-1:0] mem3,
    output logic [d_width-1:0] mem4,
    output logic [d_width-1:0] mem5,
    output logic [d_width-1:0] mem6,
    output logic [d_width-1:0] mem7
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACCESS,
        ST_DONE
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [3:0]         cnt;
    logic               rw_q;
    logic [2:0]         idx_q;
    logic [d_width-1:0] wdata_q;
    logic [d_width-1:0] rdata_q;
    logic [d_width-1:0] mem [8];
    logic               oor_q;

    // State register; reset wins over everything, including an in-flight access.
    always_ff @(posedge clk) begin
        if (clr) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (bus.req) state_nxt = ST_WAIT;
            ST_WAIT:   if (cnt == 4'd0) state_nxt = ST_ACCESS;
            ST_ACCESS: state_nxt = ST_DONE;
            ST_DONE:   state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // Request latch, latency counter, storage and read-data register.
    always_ff @(posedge clk) begin
        if (clr) begin
            cnt     <= 4'd0;
            rw_q    <= 1'b0;
            idx_q   <= 3'd0;
            wdata_q <= '0;
            rdata_q <= '0;
            oor_q   <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                mem[i] <= '0;
            end
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.req) begin
                        rw_q    <= bus.rw;
                        idx_q   <= bus.addr[2:0];
                        wdata_q <= bus.wdata;
                        cnt     <= 4'(LATENCY - 1);
`ifdef MEM_RESP_RANGE_CHECK_EN
                        oor_q   <= ((bus.addr >> 3) != '0);
`else
                        oor_q   <= 1'b0;
`endif
                    end
                end
                ST_WAIT: begin
                    // Saturate at zero so the counter can never wrap.
                    if (cnt != 4'd0) cnt <= cnt - 4'd1;
                end
                ST_ACCESS: begin
                    if (rw_q) begin
                        if (!oor_q) mem[idx_q] <= wdata_q;
                    end else begin
                        rdata_q <= oor_q ? '0 : mem[idx_q];
                    end
                end
                default: ;
            endcase
        end
    end

    // Handshake outputs are pure decodes of the state.
    always_comb begin
        bus.ready = (state == ST_IDLE);
        bus.busy  = (state != ST_IDLE);
        bus.ack   = (state == ST_DONE);
        bus.rdata = rdata_q;
`ifdef MEM_RESP_RANGE_CHECK_EN
        bus.err   = (state == ST_DONE) && oor_q;
`endif
    end

    assign mem0 = mem[0];
    assign mem1 = mem[1];
    assign mem2 = mem[2];
    assign mem3 = mem[3];
    assign mem4 = mem[4];
    assign mem5 = mem[5];
    assign mem6 = mem[6];
    assign mem7 = mem[7];

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: stimulus pushes expected completions,
// a negedge monitor pops and compares whenever ack is seen.
module tb_mem_responder;
    localparam int DW  = 8;
    localparam int AW  = 8;
    localparam int LAT = 3;

    typedef struct {
        logic [DW-1:0] rdata;
        logic          err;
        int            ack_cycle;
    } exp_t;

    logic clk = 1'b0;
    logic clr = 1'b1;
    logic [DW-1:0] mem0, mem1, mem2, mem3, mem4, mem5, mem6, mem7;
    logic [DW-1:0] mem_w [8];

    mem_responder_if #(.d_width(DW), .a_width(AW)) bus ();

    mem_responder #(.d_width(DW), .a_width(AW), .LATENCY(LAT)) dut (
        .clk  (clk),
        .clr  (clr),
        .bus  (bus),
        .mem0 (mem0), .mem1 (mem1), .mem2 (mem2), .mem3 (mem3),
        .mem4 (mem4), .mem5 (mem5), .mem6 (mem6), .mem7 (mem7)
    );

    assign mem_w[0] = mem0; assign mem_w[1] = mem1;
    assign mem_w[2] = mem2; assign mem_w[3] = mem3;
    assign mem_w[4] = mem4; assign mem_w[5] = mem5;
    assign mem_w[6] = mem6; assign mem_w[7] = mem7;

    always #5 clk = ~clk;

    int cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    int   vectors = 0;
    int   miscompares = 0;
    int   ack_count = 0;
    int   last_ack = 0;
    int   last_ack_prev = 0;
    exp_t exp_q [$];

    logic [DW-1:0] model_mem [8];
    logic [DW-1:0] model_rdata;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    task automatic finish_sim();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) model_mem[i] = '0;
        model_rdata = '0;
    endtask

    // Compare every completion against the oldest expectation.
    always @(negedge clk) begin
        if (!clr && bus.ack) begin
            exp_t e;
            ack_count++;
            last_ack_prev = last_ack;
            last_ack = cycle;
            check("ack_expected", 32'(exp_q.size() != 0), 32'd1);
            check("busy_with_ack", {30'd0, bus.busy, bus.ready}, 32'd2);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("rdata", 32'(bus.rdata), 32'(e.rdata));
                check("ack_cycle", 32'(cycle), 32'(e.ack_cycle));
`ifdef MEM_RESP_RANGE_CHECK_EN
                check("err", 32'(bus.err), 32'(e.err));
`endif
                for (int i = 0; i < 8; i++) begin
                    check($sformatf("mem%0d", i), 32'(mem_w[i]), 32'(model_mem[i]));
                end
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        @(negedge clk);
        while (!bus.ready && n < 64) begin
            @(negedge clk);
            n++;
        end
        if (!bus.ready) begin
            check("ready_timeout", 32'(bus.ready), 32'd1);
            finish_sim();
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while ((exp_q.size() != 0 || !bus.ready) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("drain", 32'(exp_q.size()), 32'd0);
    endtask

    // Issue one access: model it, push its expected completion, then optionally
    // wiggle junk requests while busy and optionally keep req high afterwards.
    task automatic issue(input logic rw, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                         input int junk, input bit drop);
        exp_t e;
        logic [2:0] idx;
        logic oor;
        wait_ready();
        bus.req   = 1'b1;
        bus.rw    = rw;
        bus.addr  = a;
        bus.wdata = wd;
        idx = a[2:0];
`ifdef MEM_RESP_RANGE_CHECK_EN
        oor = (a > 7);
`else
        oor = 1'b0;
`endif
        if (rw) begin
            if (!oor) model_mem[idx] = wd;
        end else begin
            model_rdata = oor ? '0 : model_mem[idx];
        end
        e.rdata = model_rdata;
        e.err = oor;
        e.ack_cycle = cycle + 1 + LAT + 1;
        exp_q.push_back(e);
        @(posedge clk);
        for (int k = 0; k < junk; k++) begin
            @(negedge clk);
            bus.req   = 1'b1;
            bus.rw    = 1'($urandom);
            bus.addr  = AW'($urandom);
            bus.wdata = DW'($urandom);
        end
        if (drop) begin
            @(negedge clk);
            bus.req = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        clr = 1'b1;
        repeat (2) @(negedge clk);
        clr = 1'b0;
        model_reset();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        bus.req = 1'b0;
        bus.rw = 1'b0;
        bus.addr = '0;
        bus.wdata = '0;
        model_reset();

        // Reset then idle.
        do_reset();
        @(negedge clk);
        check("rst_ready", 32'(bus.ready), 32'd1);
        check("rst_ack", 32'(bus.ack), 32'd0);
        check("rst_rdata", 32'(bus.rdata), 32'd0);
        for (int i = 0; i < 8; i++) check($sformatf("rst_mem%0d", i), 32'(mem_w[i]), 32'd0);

        // Write then read back.
        issue(1'b1, 8'd3, 8'hA5, 0, 1'b1);
        issue(1'b0, 8'd3, 8'h00, 0, 1'b1);
        wait_idle();
        check("rd_back_a5", 32'(bus.rdata), 32'hA5);

        // Requests while busy are ignored.
        c0 = ack_count;
        issue(1'b1, 8'd2, 8'h11, 0, 1'b0);
        @(negedge clk);
        bus.req = 1'b1; bus.rw = 1'b1; bus.addr = 8'd5; bus.wdata = 8'hFF;
        @(negedge clk);
        bus.req = 1'b0;
        wait_idle();
        repeat (3) @(negedge clk);
        check("busy_ignore_acks", 32'(ack_count - c0), 32'd1);
        check("busy_ignore_mem5", 32'(mem5), 32'd0);
        check("busy_ignore_mem2", 32'(mem2), 32'h11);

        // Reset during ACCESS kills the write and the ack.
        c0 = ack_count;
        wait_ready();
        bus.req = 1'b1; bus.rw = 1'b1; bus.addr = 8'd1; bus.wdata = 8'h7E;
        @(posedge clk);
        @(negedge clk);
        bus.req = 1'b0;
        repeat (LAT) @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        check("midrst_ack", 32'(bus.ack), 32'd0);
        check("midrst_mem1", 32'(mem1), 32'd0);
        check("midrst_ready", 32'(bus.ready), 32'd1);
        clr = 1'b0;
        model_reset();
        repeat (4) @(negedge clk);
        check("midrst_no_ack", 32'(ack_count - c0), 32'd0);
        check("midrst_mem1_after", 32'(mem1), 32'd0);
        check("midrst_mem2_cleared", 32'(mem2), 32'd0);
        check("midrst_idle", 32'(bus.ready), 32'd1);

        // Back-to-back with req held high.
        issue(1'b1, 8'd0, 8'h5A, 0, 1'b0);
        issue(1'b1, 8'd1, 8'hC3, 0, 1'b1);
        wait_idle();
        check("b2b_spacing", 32'(last_ack - last_ack_prev), 32'(LAT + 3));

        // Aliasing / range check on addr=9.
        issue(1'b1, 8'd1, 8'h3C, 0, 1'b1);
        issue(1'b0, 8'd9, 8'h00, 0, 1'b1);
        wait_idle();
`ifdef MEM_RESP_RANGE_CHECK_EN
        check("range_rdata", 32'(bus.rdata), 32'h00);
`else
        check("alias_rdata", 32'(bus.rdata), 32'h3C);
`endif

        // Randomized traffic with busy-time junk and back-to-back runs.
        for (int n = 0; n < 150; n++) begin
            logic rw;
            logic [AW-1:0] a;
            int junk;
            bit drop;
            rw = 1'($urandom);
            a = ($urandom_range(0, 9) == 0) ? AW'($urandom) : AW'($urandom_range(0, 15));
            junk = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, LAT + 2)) : 0;
            drop = (n == 149) ? 1'b1 : ($urandom_range(0, 3) != 0);
            issue(rw, a, DW'($urandom), junk, drop);
            if (drop) repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        wait_idle();
        check("final_rdata", 32'(bus.rdata), 32'(model_rdata));
        for (int i = 0; i < 8; i++) check($sformatf("final_mem%0d", i), 32'(mem_w[i]), 32'(model_mem[i]));

        finish_sim();
    end
endmodule
